uart_baud_gen: RTL
==================

Name: uart_baud_gen

Overview:
- Parametrised bit-timing generator for the UART RX/TX paths. Successor to the fixed 9600-baud mid-bit strobe generator.
- Adds a runtime-loadable divisor, a start/stop handshake so RX can align bit timing to the start-bit edge, and a frame bit counter.
- Provides mid-bit and end-of-bit strobes, frame-done, and free-running vs single-frame modes.
- Sits between the start-bit detector / TX controller and the shift registers.

Parameters:
- CNT_W, 16: width of the divisor and the bit-period counter.
- DIV_RESET, 256: clocks per bit after reset (2.4576 MHz / 9600).
- FRAME_BITS, 10: bit periods per frame (start + 8 data + stop); legal range 1 to 2^BIDX_W.
- BIDX_W, 4: width of bit_idx.

Ports:
- clk  in  1  system clock (2.4576 MHz nominal).
- reset_n  in  1  asynchronous active-low reset.
- baud_div  in  CNT_W  clocks per bit; captured on div_load.
- div_load  in  1  single-cycle strobe; loads baud_div into the divisor register.
- cont  in  1  1 = free-running (frames repeat), 0 = stop after one frame; sampled every cycle.
- start  in  1  single-cycle strobe; begins or resynchronises a frame.
- stop  in  1  single-cycle strobe; aborts to idle.
- busy  out  1  high while in RUN.
- mid_tick  out  1  one-cycle strobe at bit centre (RX sample point).
- bit_tick  out  1  one-cycle strobe in the last clock of each bit (TX shift point).
- bit_idx  out  BIDX_W  index of the current bit within the frame (0-based).
- frame_done  out  1  one-cycle strobe coincident with the bit_tick of bit FRAME_BITS-1.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, cnt=0, bit_idx=0, div=DIV_RESET.
  - busy, mid_tick, bit_tick and frame_done are all 0.
- Divisor register:
  - Loads baud_div on div_load only in IDLE.
  - div_load in RUN is ignored; the divisor never changes mid-frame.
  - Loaded values 0 and 1 clamp to 2.
  - div_load and start in the same cycle: the new divisor loads and that frame uses it.
- States: IDLE, RUN. Two states only; busy = (state==RUN).
- IDLE:
  - cnt and bit_idx are held at 0; all ticks are 0.
  - start → RUN at the next edge, with cnt=0 and bit_idx=0.
- RUN, counter:
  - cnt increments each clock from 0 to div-1, then wraps to 0.
  - half = div>>1 (floor).
- RUN, tick outputs (combinational decode of the registered state):
  - mid_tick = RUN && cnt==half.
  - bit_tick = RUN && cnt==div-1.
  - frame_done = bit_tick && bit_idx==FRAME_BITS-1.
- RUN, bit index:
  - On bit_tick, bit_idx increments.
  - When frame_done is high: bit_idx wraps to 0. If cont=1, stay in RUN. If cont=0, go to IDLE at that edge.
- Latency:
  - First RUN cycle (cnt=0) is the cycle after start is sampled.
  - mid_tick occurs half cycles later; bit_tick occurs div-1 cycles later.
- start while in RUN (resync): cnt=0 and bit_idx=0 at the next edge. Any tick in that same cycle is still output normally.
- stop: takes priority over start, div_load-related start and frame completion. At the next edge the block is IDLE with cnt=0 and bit_idx=0. frame_done is suppressed from that edge onward.
- Simultaneous start + frame_done with cont=0: start wins; the block stays in RUN with a new frame from cnt=0.
- Width rules:
  - cnt compares against div-1 in CNT_W bits. No overflow is possible because div ≥ 2.
  - bit_idx never exceeds FRAME_BITS-1.

Test Plan:
- Reset then default: release reset_n, pulse start, cont=0 → mid_tick first at 128 cycles after the first RUN cycle, bit_tick at 255. 10 bit_ticks total; frame_done on the 10th; busy drops after 2560 RUN cycles.
- Load divisor: div_load with baud_div=8 in IDLE, then start → mid_tick at cnt=4, bit_tick every 8 cycles, frame_done after 80 cycles, bit_idx sequence 0..9. baud_div=1 → behaves as div=2.
- Continuous mode: div=8, cont=1, start → frame_done every 80 cycles, busy stays 1, bit_idx wraps 9→0. Drop cont to 0 → the block stops at the next frame_done.
- Resync: div=8; at cnt=5 of bit 3 pulse start → next cycle cnt=0, bit_idx=0, and the next mid_tick comes 4 cycles later.
- Abort and priority: stop asserted together with start at the final bit_tick → no further ticks, busy=0 next cycle. div_load during RUN → period unchanged until IDLE.
- Async reset mid-frame: drop reset_n between edges at bit 5 → all outputs 0 immediately and div=256, with no clock edge needed.

Source files
------------

// File: rtl/uart_baud_gen.sv
// Bit-timing generator for the UART RX/TX paths: runtime-loadable divisor,
// mid-bit and end-of-bit strobes, frame bit counter and single/continuous frame modes.
module uart_baud_gen #(
    parameter int CNT_W      = 16,
    parameter int DIV_RESET  = 256,
    parameter int FRAME_BITS = 10,
    parameter int BIDX_W     = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [CNT_W-1:0]  baud_div,
    input  logic              div_load,
    input  logic              cont,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic [BIDX_W-1:0] bit_idx,
    output logic              frame_done
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [CNT_W-1:0]  DIV_INIT = CNT_W'(DIV_RESET);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DIV_MIN  = CNT_W'(2);
    localparam logic [BIDX_W-1:0] IDX_ONE  = BIDX_W'(1);
    localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(FRAME_BITS - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CNT_W-1:0]  div_reg, div_next;
    logic [BIDX_W-1:0] bit_idx_reg, bit_idx_next;
    logic [CNT_W-1:0]  half;
    logic [CNT_W-1:0]  div_m1;
    logic              run;

    assign run    = (state_reg == RUN);
    assign half   = div_reg >> 1;
    assign div_m1 = div_reg - CNT_ONE;

    // Strobes decode the registered state only, so they are glitch-free one-cycle pulses.
    assign busy       = run;
    assign mid_tick   = run && (cnt_reg == half);
    assign bit_tick   = run && (cnt_reg == div_m1);
    assign frame_done = bit_tick && (bit_idx_reg == LAST_IDX);
    assign bit_idx    = bit_idx_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            div_reg     <= DIV_INIT;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            div_reg     <= div_next;
        end
    end

    // The divisor is only writable while idle so a frame never sees a period change.
    always_comb begin
        div_next = div_reg;
        if (!run && div_load) begin
            div_next = (baud_div < DIV_MIN) ? DIV_MIN : baud_div;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        if (stop) begin
            state_next   = IDLE;
            cnt_next     = '0;
            bit_idx_next = '0;
        end else if (start) begin
            // Start also resynchronises a running frame to the new edge.
            state_next   = RUN;
            cnt_next     = '0;
            bit_idx_next = '0;
        end else if (run) begin
            if (bit_tick) begin
                cnt_next = '0;
                if (frame_done) begin
                    bit_idx_next = '0;
                    state_next   = cont ? RUN : IDLE;
                end else begin
                    bit_idx_next = bit_idx_reg + IDX_ONE;
                end
            end else begin
                cnt_next = cnt_reg + CNT_ONE;
            end
        end else begin
            cnt_next     = '0;
            bit_idx_next = '0;
        end
    end

endmodule
